// File: rtl/pixel_substitutor.sv
// Pixel-stream substitution cipher: c = SBOX[p ^ k] ^ c_prev, chained per frame from IV.
// The S-box is loaded by the upstream generator while in LOAD; frames then run back to back.
module pixel_substitutor #(
  parameter int         NUM_PIXELS = 65536,
  parameter logic [7:0] IV         = 8'h5A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sbox_we,
  input  logic [7:0] sbox_addr,
  input  logic [7:0] sbox_wdata,
  input  logic       done_sbox,
  input  logic       pix_in_valid,
  input  logic [7:0] pix_in,
  input  logic [7:0] key_byte,
  output logic       pix_in_ready,
  output logic       pix_out_valid,
  output logic [7:0] pix_out,
  output logic       pix_last,
  input  logic       pix_out_ready,
  output logic       frame_done,
  output logic       busy
);

  localparam int CNT_W = $clog2(NUM_PIXELS) + 1;

  typedef enum logic [1:0] {
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [7:0]       r_table [256];
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_c_prev;
  logic [7:0]       r_pix_out_p1;
  logic             r_vld_p1;
  logic             r_last_p1;

  logic [7:0]       w_index;
  logic [7:0]       w_cipher;
  logic             w_accept;
  logic             w_out_hs;
  logic             w_frame_full;
  logic             w_is_last_in;

  // Stage p0: combinational table lookup on the keyed pixel, then chaining XOR
  assign w_index      = pix_in ^ key_byte;
  assign w_cipher     = r_table[w_index] ^ r_c_prev;
  assign w_frame_full = (r_count == CNT_W'(NUM_PIXELS));
  assign w_is_last_in = (r_count == CNT_W'(NUM_PIXELS - 1));
  assign w_accept     = pix_in_valid & pix_in_ready;
  assign w_out_hs     = r_vld_p1 & pix_out_ready;

  always_comb begin
    w_state_nxt  = r_state;
    pix_in_ready = 1'b0;
    frame_done   = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (done_sbox) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // Once the final pixel of a frame is held, intake stops until it drains
        pix_in_ready = !w_frame_full && (!r_vld_p1 || pix_out_ready);
        busy         = (r_count != '0) || r_vld_p1;
        if (w_out_hs && r_last_p1) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        frame_done  = 1'b1;
        w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_LOAD;
    else      r_state <= w_state_nxt;
  end

  // Table RAM has no reset; it is always reloaded after reset
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD && sbox_we) r_table[sbox_addr] <= sbox_wdata;
  end

  // Stage p1: 1-deep output register, reloadable in the same cycle it drains
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count      <= '0;
      r_c_prev     <= IV;
      r_pix_out_p1 <= 8'h00;
      r_vld_p1     <= 1'b0;
      r_last_p1    <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_count  <= '0;
      r_c_prev <= IV;
    end else if (w_accept) begin
      r_pix_out_p1 <= w_cipher;
      r_c_prev     <= w_cipher;
      r_vld_p1     <= 1'b1;
      r_last_p1    <= w_is_last_in;
      r_count      <= r_count + CNT_W'(1);
    end else if (w_out_hs) begin
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
    end
  end

  assign pix_out_valid = r_vld_p1;
  assign pix_out       = r_pix_out_p1;
  assign pix_last      = r_last_p1;

endmodule

// File: tb/tb_pixel_substitutor.sv
// Directed bench for pixel_substitutor with a 4-pixel frame and hand-computed ciphertexts.
module tb_pixel_substitutor;

  logic       clk;
  logic       rst;
  logic       sbox_we;
  logic [7:0] sbox_addr;
  logic [7:0] sbox_wdata;
  logic       done_sbox;
  logic       pix_in_valid;
  logic [7:0] pix_in;
  logic [7:0] key_byte;
  logic       pix_in_ready;
  logic       pix_out_valid;
  logic [7:0] pix_out;
  logic       pix_last;
  logic       pix_out_ready;
  logic       frame_done;
  logic       busy;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] p;
    logic [7:0] k;
    logic [7:0] c;
    logic       last;
  } vec_t;

  vec_t vecs [8];

  pixel_substitutor #(.NUM_PIXELS(4), .IV(8'h5A)) dut (
    .clk          (clk),
    .rst          (rst),
    .sbox_we      (sbox_we),
    .sbox_addr    (sbox_addr),
    .sbox_wdata   (sbox_wdata),
    .done_sbox    (done_sbox),
    .pix_in_valid (pix_in_valid),
    .pix_in       (pix_in),
    .key_byte     (key_byte),
    .pix_in_ready (pix_in_ready),
    .pix_out_valid(pix_out_valid),
    .pix_out      (pix_out),
    .pix_last     (pix_last),
    .pix_out_ready(pix_out_ready),
    .frame_done   (frame_done),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Fill the table with i or ~i; the 0xFF entry is written in the same cycle as done_sbox
  task automatic load_table(input bit inv, input bit special);
    pix_in_valid = 1'b1;
    pix_in       = 8'h00;
    key_byte     = 8'h00;
    for (int i = 0; i < 255; i++) begin
      sbox_we    = 1'b1;
      sbox_addr  = 8'(i);
      sbox_wdata = inv ? ~8'(i) : 8'(i);
      #1;
      if (i == 100) check("load_in_ready", pix_in_ready, 0);
      tick();
    end
    sbox_addr  = 8'hFF;
    sbox_wdata = special ? 8'h3C : (inv ? 8'h00 : 8'hFF);
    done_sbox  = 1'b1;
    tick();
    sbox_we      = 1'b0;
    done_sbox    = 1'b0;
    pix_in_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] p, input logic [7:0] k, input logic [7:0] exp_c,
                      input logic exp_last, input string nm);
    int n;
    pix_in       = p;
    key_byte     = k;
    pix_in_valid = 1'b1;
    #1;
    n = 0;
    while (!pix_in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!pix_in_ready) begin
      check({nm, "_ready_timeout"}, 0, 1);
      pix_in_valid = 1'b0;
      return;
    end
    tick();
    pix_in_valid = 1'b0;
    #1;
    check({nm, "_valid"}, pix_out_valid, 1);
    check({nm, "_data"}, pix_out, exp_c);
    check({nm, "_last"}, pix_last, exp_last);
  endtask

  task automatic frame_end(input string nm);
    tick();
    check({nm, "_frame_done_pulse"}, frame_done, 1);
    check({nm, "_out_drained"}, pix_out_valid, 0);
    tick();
    check({nm, "_frame_done_clear"}, frame_done, 0);
    check({nm, "_idle"}, busy, 0);
  endtask

  initial begin
    vecs[0] = '{8'h10, 8'hFF, 8'h4A, 1'b0};
    vecs[1] = '{8'h20, 8'hFF, 8'h6A, 1'b0};
    vecs[2] = '{8'h30, 8'hFF, 8'h5A, 1'b0};
    vecs[3] = '{8'h40, 8'hFF, 8'h1A, 1'b1};
    vecs[4] = '{8'h10, 8'hFF, 8'h4A, 1'b0};
    vecs[5] = '{8'h20, 8'hFF, 8'h6A, 1'b0};
    vecs[6] = '{8'h30, 8'hFF, 8'h5A, 1'b0};
    vecs[7] = '{8'h40, 8'hFF, 8'h1A, 1'b1};

    rst           = 1'b0;
    sbox_we       = 1'b0;
    sbox_addr     = 8'h00;
    sbox_wdata    = 8'h00;
    done_sbox     = 1'b0;
    pix_in_valid  = 1'b0;
    pix_in        = 8'h00;
    key_byte      = 8'h00;
    pix_out_ready = 1'b1;
    #1;
    check("rst_in_ready", pix_in_ready, 0);
    check("rst_out_valid", pix_out_valid, 0);
    check("rst_pix_out", pix_out, 0);
    check("rst_last", pix_last, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    tick();
    tick();
    rst = 1'b1;

    // Identity table: first two pixels of a frame
    load_table(1'b0, 1'b0);
    send(8'h00, 8'h00, 8'h5A, 1'b0, "id_p0");
    send(8'h01, 8'h00, 8'h5B, 1'b0, "id_p1");
    check("id_busy", busy, 1);

    // Asynchronous reset while an output is pending
    #2;
    rst = 1'b0;
    #1;
    check("arst_out_valid", pix_out_valid, 0);
    check("arst_pix_out", pix_out, 0);
    check("arst_in_ready", pix_in_ready, 0);
    check("arst_busy", busy, 0);
    check("arst_last", pix_last, 0);
    check("arst_frame_done", frame_done, 0);
    tick();
    tick();
    rst = 1'b1;

    // Inverted table, entry 0xFF overwritten with 0x3C in the done_sbox cycle
    load_table(1'b1, 1'b1);
    send(8'hFF, 8'h00, 8'h66, 1'b0, "ff_p0");
    send(8'h00, 8'h00, 8'h99, 1'b0, "ff_p1");
    send(8'h01, 8'h00, 8'h67, 1'b0, "ff_p2");
    send(8'h02, 8'h00, 8'h9A, 1'b1, "ff_p3");
    frame_end("ff");

    // Two consecutive frames from the vector table
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].p, vecs[i].k, vecs[i].c, vecs[i].last, $sformatf("vec%0d", i));
      if (vecs[i].last) frame_end($sformatf("vec%0d", i));
    end

    // Table write attempt in RUN must be ignored
    sbox_we    = 1'b1;
    sbox_addr  = 8'h00;
    sbox_wdata = 8'hAA;
    tick();
    sbox_we = 1'b0;

    // Backpressure: output stalls for 5 cycles with the next pixel waiting
    pix_out_ready = 1'b0;
    send(8'h00, 8'h00, 8'hA5, 1'b0, "bp_p0");
    pix_in       = 8'h11;
    key_byte     = 8'h0F;
    pix_in_valid = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_stall%0d_in_ready", i), pix_in_ready, 0);
      check($sformatf("bp_stall%0d_data", i), pix_out, 8'hA5);
      check($sformatf("bp_stall%0d_valid", i), pix_out_valid, 1);
      tick();
    end
    pix_out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", pix_in_ready, 1);
    tick();
    pix_in_valid = 1'b0;
    #1;
    check("bp_p1_valid", pix_out_valid, 1);
    check("bp_p1_data", pix_out, 8'h44);
    check("bp_p1_last", pix_last, 0);
    send(8'h22, 8'h0F, 8'h96, 1'b0, "bp_p2");
    send(8'h33, 8'h0F, 8'h55, 1'b1, "bp_p3");
    frame_end("bp");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
